// File: rtl/ofdm_ifft_reorder.sv
// ofdm_ifft_reorder: bit-reversal reorder buffer between the IFFT core and
// the cyclic-prefix adder. Two ping-pong banks of N samples. The writer
// fills a bank in bit-reversed address order. The reader drains full banks
// in natural order as a valid/sop/eop stream, with a 2-cycle latency from
// the completing eop beat.
// Optional feature macro: OFDM_REORDER_ERRCNT_EN (adds the err_count port).
module ofdm_ifft_reorder #(
    parameter int DATA_W = 22,
    parameter int LOG2N  = 6
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] asi_in0_data,
    input  logic              asi_in0_valid,
    input  logic              asi_in0_startofpacket,
    input  logic              asi_in0_endofpacket,
    output logic [DATA_W-1:0] aso_out0_data,
    output logic              aso_out0_valid,
    output logic              aso_out0_startofpacket,
    output logic              aso_out0_endofpacket
`ifdef OFDM_REORDER_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N:0]   K_LAST = {1'b0, {LOG2N{1'b1}}};
    localparam logic [LOG2N-1:0] R_LAST = {LOG2N{1'b1}};

    typedef enum logic {W_IDLE, W_FILL} wr_state_t;
    typedef enum logic {R_IDLE, R_RUN}  rd_state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] res;
        for (int i = 0; i < LOG2N; i++) res[i] = v[LOG2N-1-i];
        return res;
    endfunction

    // Storage: bank index in the MSB of the address.
    logic [DATA_W-1:0] mem [0:2*N-1];

    logic [1:0]       full, full_nxt;
    wr_state_t        wr_state, wr_state_nxt;
    logic             wb;
    logic [LOG2N:0]   k, k_nxt;
    logic             k_last;
    logic             wr_en, wr_done, wr_full_eff;
    logic [LOG2N-1:0] wr_addr;

    rd_state_t        rd_state, rd_state_nxt;
    logic             rb;
    logic [LOG2N-1:0] r, r_nxt;
    logic             rd_go, rd_issue, rd_clear;

    assign k_last = (k == K_LAST);
    // Reader may start draining the bank it points at.
    assign rd_go  = full[rb];
    // A bank being released by the reader this cycle may be refilled at once.
    assign wr_full_eff = full[wb] & ~(rd_clear & (rb == wb));

    // Write FSM next state: legal beats advance k, malformed beats abort or restart.
    always_comb begin
        wr_state_nxt = wr_state;
        k_nxt        = k;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_done      = 1'b0;
        if (asi_in0_valid) begin
            case (wr_state)
                W_IDLE: begin
                    // A one-beat packet can never be complete, so sop+eop is dropped.
                    if (asi_in0_startofpacket && !wr_full_eff && !asi_in0_endofpacket) begin
                        wr_en        = 1'b1;
                        k_nxt        = K_LAST'(1);
                        wr_state_nxt = W_FILL;
                    end
                end
                W_FILL: begin
                    wr_en = 1'b1;
                    if (asi_in0_startofpacket) begin
                        k_nxt = K_LAST'(1);
                    end else begin
                        wr_addr = bitrev(k[LOG2N-1:0]);
                        k_nxt   = k + 1'b1;
                        if (k_last || asi_in0_endofpacket) begin
                            wr_state_nxt = W_IDLE;
                            k_nxt        = '0;
                            wr_done      = k_last && asi_in0_endofpacket;
                        end
                    end
                end
                default: wr_state_nxt = W_IDLE;
            endcase
        end
    end

    // Write FSM state, fill counter and write bank pointer.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_state <= W_IDLE;
            k        <= '0;
            wb       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            wr_state <= wr_state_nxt;
            k        <= k_nxt;
            if (wr_done) wb <= ~wb;
        end
    end

    // Sample RAM write port.
    always_ff @(posedge clk_clk) begin
        // NOTE: the RAM has no reset; full flags alone decide what is valid,
        // and a reset would prevent block-RAM inference.
        if (wr_en) mem[{wb, wr_addr}] <= asi_in0_data;
    end

    // Read FSM next state: address 0 is issued in the same cycle a full bank is seen.
    always_comb begin
        rd_state_nxt = rd_state;
        r_nxt        = r;
        rd_issue     = 1'b0;
        rd_clear     = 1'b0;
        case (rd_state)
            R_IDLE:  rd_issue = rd_go;
            R_RUN:   rd_issue = 1'b1;
            default: rd_issue = 1'b0;
        endcase
        if (rd_issue) begin
            if (r == R_LAST) begin
                rd_clear     = 1'b1;
                r_nxt        = '0;
                rd_state_nxt = full[~rb] ? R_RUN : R_IDLE;
            end else begin
                r_nxt        = r + 1'b1;
                rd_state_nxt = R_RUN;
            end
        end
    end

    // Read FSM state, address counter and read bank pointer.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_state <= R_IDLE;
            r        <= '0;
            rb       <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            r        <= r_nxt;
            if (rd_clear) rb <= ~rb;
        end
    end

    // Full flags: writer sets its bank, reader clears its bank; never the same bank together.
    always_comb begin
        full_nxt = full;
        if (rd_clear) full_nxt[rb] = 1'b0;
        if (wr_done)  full_nxt[wb] = 1'b1;
    end

    // Full flag register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) full <= '0;
        else                full <= full_nxt;
    end

    // Output stage: registered RAM read plus aligned qualifiers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            aso_out0_data          <= '0;
            aso_out0_valid         <= 1'b0;
            aso_out0_startofpacket <= 1'b0;
            aso_out0_endofpacket   <= 1'b0;
        end else begin
            if (rd_issue) aso_out0_data <= mem[{rb, r}];
            aso_out0_valid         <= rd_issue;
            aso_out0_startofpacket <= rd_issue && (r == '0);
            aso_out0_endofpacket   <= rd_issue && (r == R_LAST);
        end
    end

`ifdef OFDM_REORDER_ERRCNT_EN
    logic wr_err;
    // One event per discarded packet: overflow, sop+eop in idle, restart, early eop, missing eop.
    assign wr_err = asi_in0_valid &
                    ((wr_state == W_IDLE)
                        ? (asi_in0_startofpacket & (wr_full_eff | asi_in0_endofpacket))
                        : (asi_in0_startofpacket | (asi_in0_endofpacket ^ k_last)));

    // Saturating error counter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)                    err_count <= '0;
        else if (wr_err && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_ofdm_ifft_reorder.sv
// tb_ofdm_ifft_reorder: randomized self-checking bench. The model is a
// queue of expected natural-order samples with the cycle each must appear,
// derived from packet completion times and output-stream occupancy.
module tb_ofdm_ifft_reorder;

    localparam int DATA_W = 22;
    localparam int LOG2N  = 6;
    localparam int N      = 1 << LOG2N;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid, in_sop, in_eop;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_sop, out_eop;
`ifdef OFDM_REORDER_ERRCNT_EN
    logic [7:0]        err_count;
`endif

    ofdm_ifft_reorder #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
        .clk_clk                (clk),
        .reset_reset_n          (rst_n),
        .asi_in0_data           (in_data),
        .asi_in0_valid          (in_valid),
        .asi_in0_startofpacket  (in_sop),
        .asi_in0_endofpacket    (in_eop),
        .aso_out0_data          (out_data),
        .aso_out0_valid         (out_valid),
        .aso_out0_startofpacket (out_sop),
        .aso_out0_endofpacket   (out_eop)
`ifdef OFDM_REORDER_ERRCNT_EN
        ,
        .err_count              (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        int                cyc;
    } exp_t;

    exp_t              q[$];
    exp_t              ce;
    int                n_chk = 0;
    int                n_pass = 0;
    bit                chk_en = 1'b0;
    bit                lat_en = 1'b1;
    int                next_free = 0;
    int                err_exp = 0;
    int                last_t = 0;
    logic [DATA_W-1:0] pkt [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int bitrev(input int v);
        int res = 0;
        for (int i = 0; i < LOG2N; i++)
            if (((v >> i) & 1) == 1) res = res | (1 << (LOG2N - 1 - i));
        return res;
    endfunction

    task automatic err_inc();
        if (err_exp < 255) err_exp++;
    endtask

    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic s, input logic e);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic rand_pkt();
        for (int n = 0; n < N; n++) pkt[n] = DATA_W'($urandom);
    endtask

    // Legal packet: beat k carries natural sample bitrev(k).
    task automatic send_good(input bit gaps, input bit expect_out);
        int s;
        for (int k = 0; k < N; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            step(1'b1, pkt[bitrev(k)], k == 0, k == N - 1);
        end
        last_t = cyc;
        if (expect_out) begin
            s = (last_t + 2 > next_free) ? last_t + 2 : next_free;
            for (int n = 0; n < N; n++) q.push_back('{pkt[n], n == 0, n == N - 1, s + n});
            next_free = s + N;
        end
    endtask

    // Beats that never complete a packet.
    task automatic junk(input int m, input bit first_sop);
        for (int k = 0; k < m; k++) step(1'b1, DATA_W'($urandom), first_sop && k == 0, 1'b0);
    endtask

    task automatic send_short(input int last_k);
        for (int k = 0; k <= last_k; k++)
            step(1'b1, DATA_W'($urandom), k == 0, k == last_k);
        err_inc();
    endtask

    task automatic drain(input int budget);
        int b = budget;
        while (q.size() > 0 && b > 0) begin
            idle(1);
            b--;
        end
        check("drain_queue_empty", q.size(), 0);
        idle(4);
    endtask

    task automatic check_err(input string name);
`ifdef OFDM_REORDER_ERRCNT_EN
        check(name, err_count, err_exp);
`endif
    endtask

    // Compare process: every cycle against the model queue.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (lat_en) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    check("sample_cycle", q[0].cyc, cyc);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    ce = q.pop_front();
                    check("out_valid", out_valid, 1);
                    check("out_data", out_data, ce.data);
                    check("out_sop", out_sop, ce.sop);
                    check("out_eop", out_eop, ce.eop);
                end else begin
                    check("idle_valid", out_valid, 0);
                end
            end else if (out_valid) begin
                check("spurious_out", q.size() > 0, 1);
                if (q.size() > 0) begin
                    ce = q.pop_front();
                    check("out_data", out_data, ce.data);
                    check("out_sop", out_sop, ce.sop);
                    check("out_eop", out_eop, ce.eop);
                end
            end
        end
    end

    initial begin
        int kind, t;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        #2 rst_n = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_sop", out_sop, 0);
        check("rst_eop", out_eop, 0);
        check("rst_data", out_data, 0);
        check_err("rst_err_count");
        check("model_bitrev_1", bitrev(1), 32);
        check("model_bitrev_6", bitrev(6), 24);
        check("model_bitrev_63", bitrev(63), 63);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Single symbol: data = natural index + 1.
        for (int n = 0; n < N; n++) pkt[n] = DATA_W'(n + 1);
        send_good(1'b0, 1'b1);
        t = last_t;
        idle(1);
        while (cyc < t + 2) @(negedge clk);
        check("single_first_data", out_data, 1);
        check("single_first_sop", out_sop, 1);
        while (cyc < t + 65) @(negedge clk);
        check("single_last_data", out_data, 64);
        check("single_last_eop", out_eop, 1);
        drain(100);

        // Back-to-back: 4 symbols, no idle cycles; gapless output enforced by the model.
        for (int p = 0; p < 4; p++) begin
            rand_pkt();
            send_good(1'b0, 1'b1);
        end
        drain(400);

        // Short packet (eop at k=10), then a good packet.
        send_short(10);
        rand_pkt();
        send_good(1'b0, 1'b1);
        drain(200);
        check_err("short_err_count");

        // sop mid-packet at k=30 restarts the fill.
        junk(30, 1'b1);
        err_inc();
        rand_pkt();
        send_good(1'b0, 1'b1);
        drain(200);
        check_err("restart_err_count");

        // Overflow: reader held, two packets fill both banks, the third is dropped.
        lat_en = 1'b0;
        force dut.rd_go = 1'b0;
        rand_pkt();
        send_good(1'b0, 1'b1);
        rand_pkt();
        send_good(1'b0, 1'b1);
        rand_pkt();
        send_good(1'b0, 1'b0);
        err_inc();
        idle(2);
        check("held_no_output", out_valid, 0);
        check_err("overflow_err_count");
        release dut.rd_go;
        drain(400);
        lat_en    = 1'b1;
        next_free = 0;

        // Randomized mix of legal and malformed packets.
        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0: send_short($urandom_range(1, N - 2));
                1: begin
                    junk($urandom_range(1, N - 2), 1'b1);
                    err_inc();
                    rand_pkt();
                    send_good($urandom_range(0, 1) == 1, 1'b1);
                end
                2: begin
                    junk(N, 1'b1);
                    err_inc();
                    junk($urandom_range(0, 3), 1'b0);
                end
                default: begin
                    rand_pkt();
                    send_good($urandom_range(0, 1) == 1, 1'b1);
                end
            endcase
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 20));
        end
        drain(400);
        check_err("random_err_count");

        // Saturation: 300 short packets.
        for (int p = 0; p < 300; p++) send_short(1);
        idle(2);
        check_err("sat_err_count_model");
`ifdef OFDM_REORDER_ERRCNT_EN
        check("sat_err_count_255", err_count, 255);
`endif

        // Reset mid-output at natural sample 20.
        rand_pkt();
        send_good(1'b0, 1'b1);
        t = last_t;
        idle(1);
        while (cyc < t + 22) @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_sop", out_sop, 0);
        check("midrst_eop", out_eop, 0);
        q.delete();
        err_exp   = 0;
        next_free = 0;
        check_err("midrst_err_count");
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(3);
        rand_pkt();
        send_good(1'b0, 1'b1);
        t = last_t;
        idle(1);
        while (cyc < t + 2) @(negedge clk);
        check("post_rst_first_data", out_data, pkt[0]);
        check("post_rst_first_sop", out_sop, 1);
        drain(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
